// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: one DIGIT-bit slice per clock, LSB first, carry held between slices.
// Optional signed saturation on overflow when SERIAL_ADDSUB_SAT_EN is defined.
module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg, sum_reg;
  logic             carry_reg, co_reg, ovf_reg;
  logic [CW-1:0]    cnt_reg;

  logic             accept, last_slice;
  logic [DIGIT:0]   slice_full;
  logic [DIGIT-1:0] slice_sum;
  logic             slice_co, msb_cin;
  logic [WIDTH-1:0] res_next, final_sum;

  assign accept     = start && (state_reg != RUN);
  assign last_slice = (cnt_reg == CW'(NDIG - 1));

  assign slice_full = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, carry_reg};
  assign slice_sum  = slice_full[DIGIT-1:0];
  assign slice_co   = slice_full[DIGIT];
  // Carry into the slice's top bit recovered from its sum; on the last slice this is the carry into the MSB.
  assign msb_cin    = a_reg[DIGIT-1] ^ b_reg[DIGIT-1] ^ slice_sum[DIGIT-1];
  assign res_next   = (res_reg >> DIGIT) | (WIDTH'(slice_sum) << (WIDTH - DIGIT));

`ifdef SERIAL_ADDSUB_SAT_EN
  logic [WIDTH-1:0] sat_value;
  // On the last slice a_reg[DIGIT-1] still holds the captured A sign bit.
  assign sat_value = a_reg[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign final_sum = (msb_cin ^ slice_co) ? sat_value : res_next;
`else
  assign final_sum = res_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_slice) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      co_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= sub ? ~b : b;
      carry_reg <= sub ? 1'b1 : ci;
      cnt_reg   <= '0;
    end else if (state_reg == RUN) begin
      a_reg     <= a_reg >> DIGIT;
      b_reg     <= b_reg >> DIGIT;
      carry_reg <= slice_co;
      res_reg   <= res_next;
      cnt_reg   <= cnt_reg + CW'(1);
      if (last_slice) begin
        sum_reg <= final_sum;
        co_reg  <= slice_co;
        ovf_reg <= msb_cin ^ slice_co;
      end
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign sum  = sum_reg;
  assign co   = co_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub (WIDTH=16, DIGIT=4): add/sub results, handshake timing, reset.
module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        ci = 1'b0;
  logic        busy, done, co, ovf;
  logic [15:0] sum;

  int vec_cnt = 0;
  int err_cnt = 0;

  serial_addsub #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
    .busy(busy), .done(done), .sum(sum), .co(co), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Called at a negedge; leaves start low at the negedge of the first RUN cycle.
  task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic sv, input logic cv);
    a = av; b = bv; sub = sv; ci = cv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles until done is seen at a negedge; -1 if it never arrives.
  task automatic wait_done(output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) return;
      if (busy) busy_cycles++;
      @(negedge clk);
    end
    busy_cycles = -1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    vec_cnt++;
    if ({busy, done, sum, co, ovf} !== 19'd0) begin
      err_cnt++;
      $display("FAIL reset_state: got busy=%b done=%b sum=%h co=%b ovf=%b, want all 0", busy, done, sum, co, ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add;
    int bc;
    logic [15:0] exp_sum;
    // 0x1234 + 0x0FED + 1 = 0x2222
    launch(16'h1234, 16'h0FED, 1'b0, 1'b1);
    wait_done(bc);
    vec_cnt++;
    if (bc !== 4) begin
      err_cnt++; $display("FAIL add_busy_cycles: got %0d, want 4", bc);
    end
    vec_cnt++;
    if ({sum, co, ovf, busy} !== {16'h2222, 1'b0, 1'b0, 1'b0}) begin
      err_cnt++; $display("FAIL add_basic: got sum=%h co=%b ovf=%b busy=%b, want 2222 0 0 0", sum, co, ovf, busy);
    end
    @(negedge clk);
    vec_cnt++;
    if ({done, sum} !== {1'b0, 16'h2222}) begin
      err_cnt++; $display("FAIL done_pulse_hold: got done=%b sum=%h, want 0 2222", done, sum);
    end
    launch(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_done(bc);
    vec_cnt++;
    if ({sum, co, ovf} !== {16'h0000, 1'b1, 1'b0}) begin
      err_cnt++; $display("FAIL add_carry_out: got sum=%h co=%b ovf=%b, want 0000 1 0", sum, co, ovf);
    end
    @(negedge clk);
    launch(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_done(bc);
`ifdef SERIAL_ADDSUB_SAT_EN
    exp_sum = 16'h7FFF;
`else
    exp_sum = 16'h8000;
`endif
    vec_cnt++;
    if ({sum, co, ovf} !== {exp_sum, 1'b0, 1'b1}) begin
      err_cnt++; $display("FAIL add_overflow: got sum=%h co=%b ovf=%b, want %h 0 1", sum, co, ovf, exp_sum);
    end
    @(negedge clk);
  endtask

  task automatic test_sub;
    int bc;
    logic [15:0] exp_sum;
    launch(16'h0005, 16'h0007, 1'b1, 1'b1);
    wait_done(bc);
    vec_cnt++;
    if ({sum, co, ovf} !== {16'hFFFE, 1'b0, 1'b0}) begin
      err_cnt++; $display("FAIL sub_borrow: got sum=%h co=%b ovf=%b, want fffe 0 0", sum, co, ovf);
    end
    @(negedge clk);
    launch(16'h8000, 16'h0001, 1'b1, 1'b0);
    wait_done(bc);
`ifdef SERIAL_ADDSUB_SAT_EN
    exp_sum = 16'h8000;
`else
    exp_sum = 16'h7FFF;
`endif
    vec_cnt++;
    if ({sum, co, ovf} !== {exp_sum, 1'b1, 1'b1}) begin
      err_cnt++; $display("FAIL sub_overflow: got sum=%h co=%b ovf=%b, want %h 1 1", sum, co, ovf, exp_sum);
    end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy;
    int done_cnt;
    // 0x0100 + 0x0020 - first operands only; later ones must be ignored
    launch(16'h0100, 16'h0020, 1'b0, 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; a = 16'hAAAA + 16'(i); b = 16'h5555; sub = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        done_cnt++;
        vec_cnt++;
        if (sum !== 16'h0120) begin
          err_cnt++; $display("FAIL busy_ignore_sum: got %h, want 0120", sum);
        end
      end
      @(negedge clk);
    end
    vec_cnt++;
    if (done_cnt !== 1) begin
      err_cnt++; $display("FAIL busy_ignore_pulses: got %0d done pulses, want 1", done_cnt);
    end
  endtask

  task automatic test_back_to_back;
    int bc, gap;
    launch(16'h0003, 16'h0004, 1'b0, 1'b0);
    wait_done(bc);
    vec_cnt++;
    if (sum !== 16'h0007) begin
      err_cnt++; $display("FAIL b2b_first: got %h, want 0007", sum);
    end
    a = 16'h0001; b = 16'h0001; sub = 1'b0; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    gap = 1;
    vec_cnt++;
    if ({busy, done} !== 2'b10) begin
      err_cnt++; $display("FAIL b2b_rebusy: got busy=%b done=%b, want 1 0", busy, done);
    end
    while (!done && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    vec_cnt++;
    if (gap !== 5) begin
      err_cnt++; $display("FAIL b2b_gap: got %0d cycles between done pulses, want 5", gap);
    end
    vec_cnt++;
    if (sum !== 16'h0002) begin
      err_cnt++; $display("FAIL b2b_second: got %h, want 0002", sum);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int bc, done_cnt;
    launch(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({busy, done, sum, co, ovf} !== 19'd0) begin
      err_cnt++;
      $display("FAIL reset_mid_run: got busy=%b done=%b sum=%h co=%b ovf=%b, want all 0", busy, done, sum, co, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) done_cnt++;
      @(negedge clk);
    end
    vec_cnt++;
    if (done_cnt !== 0) begin
      err_cnt++; $display("FAIL reset_discard: got %0d busy/done cycles after reset, want 0", done_cnt);
    end
    launch(16'h1111, 16'h2222, 1'b0, 1'b1);
    wait_done(bc);
    vec_cnt++;
    if ({bc, sum, co, ovf} !== {32'sd4, 16'h3334, 1'b0, 1'b0}) begin
      err_cnt++; $display("FAIL reset_recover: got cycles=%0d sum=%h co=%b ovf=%b, want 4 3334 0 0", bc, sum, co, ovf);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_start_while_busy;
    test_back_to_back;
    test_reset_mid_run;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
